// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board: FSM states,
// winner codes and the eight three-in-a-row masks.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    HUMAN_TURN = 2'd0,
    AI_TURN    = 2'd1,
    CHECK      = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int NUM_LINES = 8;

  // Bit n of a mask is cell n (a..i). Element 0 is the rightmost entry.
  localparam logic [NUM_LINES-1:0][8:0] WIN_LINES = {
    9'h054, 9'h111,          // diagonals 2-4-6, 0-4-8
    9'h124, 9'h092, 9'h049,  // columns 2-5-8, 1-4-7, 0-3-6
    9'h1C0, 9'h038, 9'h007   // rows 6-7-8, 3-4-5, 0-1-2
  };

endpackage

// File: rtl/tictactoe_win_check.sv
// Combinational three-in-a-row detector for one player's ownership vector.
module tictactoe_win_check
  import tictactoe_pkg::*;
(
  input  logic [8:0] cells,
  output logic       win
);

  logic [NUM_LINES-1:0] hit;

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    assign hit[k] = (cells & WIN_LINES[k]) == WIN_LINES[k];
  end

  assign win = |hit;

endmodule

// File: rtl/tictactoe_board.sv
// Board state and move arbiter: edge-detects both press sources, validates
// moves, alternates turns and latches the game result.
module tictactoe_board
  import tictactoe_pkg::*;
#(
  parameter int FIRST_PLAYER = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] human_btn,
  input  logic [8:0] ai_btn,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       i,
  output logic [8:0] x_cells,
  output logic [8:0] o_cells,
  output logic       ai_turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       illegal_move
);

  localparam state_t START = (FIRST_PLAYER != 0) ? AI_TURN : HUMAN_TURN;

  state_t     state, state_next;
  logic [8:0] human_q, ai_q;
  logic [8:0] h_rise, a_rise, occ;
  logic [8:0] x_next, o_next;
  logic [1:0] winner_next;
  logic       over_next, illegal_next;
  logic       mover, mover_next;  // 0: X moved last, 1: O moved last
  logic       win;

  assign h_rise = human_btn & ~human_q;
  assign a_rise = ai_btn & ~ai_q;
  assign occ    = x_cells | o_cells;

  tictactoe_win_check u_win (
    .cells (mover ? o_cells : x_cells),
    .win   (win)
  );

  always_comb begin
    state_next   = state;
    x_next       = x_cells;
    o_next       = o_cells;
    winner_next  = winner;
    over_next    = game_over;
    illegal_next = 1'b0;
    mover_next   = mover;
    case (state)
      HUMAN_TURN:
        if ($onehot(h_rise)) begin
          if (|(h_rise & occ)) illegal_next = 1'b1;
          else begin
            x_next     = x_cells | h_rise;
            mover_next = 1'b0;
            state_next = CHECK;
          end
        end
      AI_TURN:
        if ($onehot(a_rise)) begin
          if (|(a_rise & occ)) illegal_next = 1'b1;
          else begin
            o_next     = o_cells | a_rise;
            mover_next = 1'b1;
            state_next = CHECK;
          end
        end
      CHECK:
        if (win) begin
          state_next  = GAME_OVER;
          over_next   = 1'b1;
          winner_next = mover ? WIN_O : WIN_X;
        end else if (&occ) begin
          state_next  = GAME_OVER;
          over_next   = 1'b1;
          winner_next = WIN_DRAW;
        end else begin
          state_next  = mover ? HUMAN_TURN : AI_TURN;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= START;
    else        state <= state_next;
  end

  // All-ones history means a level held through reset must drop before it counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      human_q      <= 9'h1FF;
      ai_q         <= 9'h1FF;
      x_cells      <= '0;
      o_cells      <= '0;
      winner       <= WIN_NONE;
      game_over    <= 1'b0;
      illegal_move <= 1'b0;
      mover        <= 1'b0;
    end else begin
      human_q      <= human_btn;
      ai_q         <= ai_btn;
      x_cells      <= x_next;
      o_cells      <= o_next;
      winner       <= winner_next;
      game_over    <= over_next;
      illegal_move <= illegal_next;
      mover        <= mover_next;
    end
  end

  assign {i, h, g, f, e, d, c, b, a} = occ;
  assign ai_turn = (state == AI_TURN);

endmodule

// File: tb/tb_tictactoe_board.sv
// Directed bench: one board with human first, one with AI first, sharing stimulus.
module tb_tictactoe_board;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] human_btn, ai_btn;

  logic       a0, b0, c0, d0, e0, f0, g0, h0, i0;
  logic [8:0] x0, o0;
  logic       ait0, over0, ill0;
  logic [1:0] win0;

  logic       a1, b1, c1, d1, e1, f1, g1, h1, i1;
  logic [8:0] x1, o1;
  logic       ait1, over1, ill1;
  logic [1:0] win1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tictactoe_board #(.FIRST_PLAYER(0)) dut0 (
    .clk(clk), .reset(reset), .human_btn(human_btn), .ai_btn(ai_btn),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .h(h0), .i(i0),
    .x_cells(x0), .o_cells(o0), .ai_turn(ait0), .game_over(over0),
    .winner(win0), .illegal_move(ill0)
  );

  tictactoe_board #(.FIRST_PLAYER(1)) dut1 (
    .clk(clk), .reset(reset), .human_btn(human_btn), .ai_btn(ai_btn),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1), .i(i1),
    .x_cells(x1), .o_cells(o1), .ai_turn(ait1), .game_over(over1),
    .winner(win1), .illegal_move(ill1)
  );

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One press: level high for one edge, then released for one edge.
  task automatic hp(input logic [8:0] m);
    human_btn = m; step(); human_btn = '0; step();
  endtask

  task automatic ap(input logic [8:0] m);
    ai_btn = m; step(); ai_btn = '0; step();
  endtask

  task automatic do_reset();
    reset = 1'b0; step(); reset = 1'b1; step();
  endtask

  initial begin
    reset = 1'b0; human_btn = 9'h010; ai_btn = '0;
    step(); step();
    chk("rst_x", x0, 9'h000);
    chk("rst_o", o0, 9'h000);
    chk("rst_occ", {i0, h0, g0, f0, e0, d0, c0, b0, a0}, 9'h000);
    chk("rst_winner", win0, 2'b00);
    chk("rst_over", over0, 1'b0);
    chk("rst_illegal", ill0, 1'b0);
    chk("rst_ai_turn0", ait0, 1'b0);
    chk("rst_ai_turn1", ait1, 1'b1);

    // Held through reset release: no move
    reset = 1'b1; step(); step(); step();
    chk("held_no_move", x0, 9'h000);
    human_btn = '0; step();
    human_btn = 9'h010; step();
    chk("press_x", x0, 9'h010);
    chk("press_e", e0, 1'b1);
    chk("check_ai_turn_lo", ait0, 1'b0);
    human_btn = '0; step();
    chk("ai_turn_rise", ait0, 1'b1);

    // Illegal AI press on occupied cell 4
    ai_btn = 9'h010; step();
    chk("illegal_pulse", ill0, 1'b1);
    chk("illegal_o", o0, 9'h000);
    chk("illegal_ai_turn", ait0, 1'b1);
    ai_btn = '0; step();
    chk("illegal_one_cycle", ill0, 1'b0);
    ai_btn = 9'h001; step();
    chk("ai_move_o", o0, 9'h001);
    chk("ai_turn_fall", ait0, 1'b0);
    ai_btn = '0; step();

    // Simultaneous human rises, then wrong-turn AI rise
    human_btn = 9'h003; step();
    chk("simul_illegal", ill0, 1'b0);
    chk("simul_x", x0, 9'h010);
    human_btn = '0; step();
    ai_btn = 9'h004; step();
    chk("wrong_turn_o", o0, 9'h001);
    ai_btn = '0; step();
    chk("wrong_turn_ai_turn", ait0, 1'b0);

    // X wins on the top row
    do_reset();
    hp(9'h001); ap(9'h008); hp(9'h002); ap(9'h010);
    human_btn = 9'h004; step();
    chk("xwin_x", x0, 9'h007);
    chk("xwin_over_T", over0, 1'b0);
    human_btn = '0; step();
    chk("xwin_over", over0, 1'b1);
    chk("xwin_winner", win0, 2'b01);
    hp(9'h020); ap(9'h020);
    chk("frozen_x", x0, 9'h007);
    chk("frozen_o", o0, 9'h018);
    chk("frozen_winner", win0, 2'b01);

    // Draw
    do_reset();
    hp(9'h001); ap(9'h002); hp(9'h004); ap(9'h010); hp(9'h008);
    ap(9'h040); hp(9'h080); ap(9'h100); hp(9'h020);
    chk("draw_occ", {i0, h0, g0, f0, e0, d0, c0, b0, a0}, 9'h1FF);
    chk("draw_x", x0, 9'h0AD);
    chk("draw_o", o0, 9'h152);
    chk("draw_winner", win0, 2'b11);
    chk("draw_over", over0, 1'b1);

    // AI-first board, reset mid-game with a simultaneous press
    do_reset();
    chk("ai_first_turn", ait1, 1'b1);
    ap(9'h001);
    chk("ai_first_o", o1, 9'h001);
    chk("ai_first_turn_lo", ait1, 1'b0);
    hp(9'h010);
    chk("ai_first_x", x1, 9'h010);
    chk("ai_first_back", ait1, 1'b1);
    ai_btn = 9'h002; reset = 1'b0; step();
    chk("midrst_o", o1, 9'h000);
    chk("midrst_x", x1, 9'h000);
    chk("midrst_ai_turn", ait1, 1'b1);
    reset = 1'b1; step(); step();
    chk("midrst_discard", o1, 9'h000);
    ai_btn = '0; step();
    chk("midrst_ai_turn_hold", ait1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
